// File: rtl/frame_bit_timer_if.sv
// Control/status bundle between the RX FSM (master) and frame_bit_timer (slave).
// FRAME_BIT_TIMER_RESYNC_EN adds the resync request line.
interface frame_bit_timer_if #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
);
  logic                  enable;
  logic [PRESCALE_W-1:0] prescale;
  logic [BIT_CNT_W-1:0]  frame_bits;
`ifdef FRAME_BIT_TIMER_RESYNC_EN
  logic                  resync;
`endif
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  bit_tick;
  logic                  sample_en;
  logic                  frame_done;
  logic                  busy;

  modport master (
`ifdef FRAME_BIT_TIMER_RESYNC_EN
    output resync,
`endif
    output enable, prescale, frame_bits,
    input  edge_cnt, bit_cnt, bit_tick, sample_en, frame_done, busy
  );

  modport slave (
`ifdef FRAME_BIT_TIMER_RESYNC_EN
    input  resync,
`endif
    input  enable, prescale, frame_bits,
    output edge_cnt, bit_cnt, bit_tick, sample_en, frame_done, busy
  );
endinterface

// File: rtl/frame_bit_timer.sv
// Oversampling edge/bit counter with frame-boundary config latching and timing strobes.
// Define FRAME_BIT_TIMER_RESYNC_EN to enable edge-phase realignment via bus.resync.
module frame_bit_timer #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
) (
  input logic            CLK,
  input logic            RST,
  frame_bit_timer_if.slave bus
);

  localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(4);
  localparam logic [BIT_CNT_W-1:0]  F_MIN = BIT_CNT_W'(2);
  localparam logic [PRESCALE_W-1:0] ONE_P = PRESCALE_W'(1);
  localparam logic [BIT_CNT_W-1:0]  ONE_B = BIT_CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [BIT_CNT_W-1:0]  f_q, f_d;

  logic [PRESCALE_W-1:0] p_eff;
  logic [BIT_CNT_W-1:0]  f_eff;
  logic [PRESCALE_W-1:0] mid;
  logic                  run;
  logic                  last_edge;
  logic                  last_bit;
  logic                  resync_req;

  // Clamp the raw configuration to the smallest usable bit/frame lengths
  assign p_eff = (bus.prescale   < P_MIN) ? P_MIN : bus.prescale;
  assign f_eff = (bus.frame_bits < F_MIN) ? F_MIN : bus.frame_bits;

  assign run       = (state_q == RUN);
  assign last_edge = (edge_q == (p_q - ONE_P));
  assign last_bit  = (bit_q == (f_q - ONE_B));
  assign mid       = p_q >> 1;

`ifdef FRAME_BIT_TIMER_RESYNC_EN
  assign resync_req = bus.resync;
`else
  assign resync_req = 1'b0;
`endif

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    p_d     = p_q;
    f_d     = f_q;
    unique case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (bus.enable) begin
          p_d     = p_eff;
          f_d     = f_eff;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!bus.enable) begin
          state_d = IDLE;
          edge_d  = '0;
          bit_d   = '0;
        end else if (last_edge) begin
          edge_d = '0;
          if (last_bit) begin
            bit_d = '0;
            p_d   = p_eff;
            f_d   = f_eff;
          end else begin
            bit_d = bit_q + ONE_B;
          end
        end else if (resync_req) begin
          edge_d = '0;
        end else begin
          edge_d = edge_q + ONE_P;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      p_q     <= P_MIN;
      f_q     <= F_MIN;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      p_q     <= p_d;
      f_q     <= f_d;
    end
  end

  // Strobes decode the registered counters so they align with the visible count
  assign bus.edge_cnt   = edge_q;
  assign bus.bit_cnt    = bit_q;
  assign bus.busy       = run;
  assign bus.bit_tick   = run && last_edge;
  assign bus.frame_done = run && last_edge && last_bit;
  assign bus.sample_en  = run && ((edge_q == (mid - ONE_P)) ||
                                  (edge_q == mid) ||
                                  (edge_q == (mid + ONE_P)));

endmodule

// File: tb/tb_frame_bit_timer.sv
// Directed, scoreboard-checked bench for frame_bit_timer (default and resync builds).
module tb_frame_bit_timer;

  localparam int unsigned PW = 6;
  localparam int unsigned BW = 4;

  logic CLK;
  logic RST;

  frame_bit_timer_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) bus_if ();

  frame_bit_timer #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int edge_v;
    int bit_v;
    int tick;
    int samp;
    int done;
    int busy;
  } exp_t;

  exp_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit obs_tick;
  bit obs_done;
  bit rs       = 1'b0;

  // Reference model state
  int m_run  = 0;
  int m_edge = 0;
  int m_bit  = 0;
  int m_p    = 4;
  int m_f    = 2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_rs(input bit v);
    rs = v;
`ifdef FRAME_BIT_TIMER_RESYNC_EN
    bus_if.resync = v;
`endif
  endtask

  function automatic int at_least(input int v, input int lo);
    return (v < lo) ? lo : v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_edge = 0; m_bit = 0; m_p = 4; m_f = 2;
  endtask

  task automatic model_next();
    int ps;
    int fb;
    ps = int'(bus_if.prescale);
    fb = int'(bus_if.frame_bits);
    if (m_run == 0) begin
      m_edge = 0;
      m_bit  = 0;
      if (bus_if.enable) begin
        m_p = at_least(ps, 4);
        m_f = at_least(fb, 2);
        m_run = 1;
      end
    end else if (!bus_if.enable) begin
      m_run = 0; m_edge = 0; m_bit = 0;
    end else if (m_edge == m_p - 1) begin
      m_edge = 0;
      if (m_bit == m_f - 1) begin
        m_bit = 0;
        m_p = at_least(ps, 4);
        m_f = at_least(fb, 2);
      end else begin
        m_bit++;
      end
    end else if (rs) begin
      m_edge = 0;
    end else begin
      m_edge++;
    end
  endtask

  // Advance one clock: predict, push, clock, pop, compare.
  task automatic step();
    exp_t e;
    exp_t g;
    model_next();
    e.edge_v = m_edge;
    e.bit_v  = m_bit;
    e.busy   = m_run;
    e.tick   = (m_run == 1 && m_edge == m_p - 1) ? 1 : 0;
    e.done   = (e.tick == 1 && m_bit == m_f - 1) ? 1 : 0;
    e.samp   = (m_run == 1 && m_edge >= m_p / 2 - 1 && m_edge <= m_p / 2 + 1) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    cyc++;
    g = exp_q.pop_front();
    check("edge_cnt",   32'(bus_if.edge_cnt),   32'(g.edge_v));
    check("bit_cnt",    32'(bus_if.bit_cnt),    32'(g.bit_v));
    check("bit_tick",   32'(bus_if.bit_tick),   32'(g.tick));
    check("sample_en",  32'(bus_if.sample_en),  32'(g.samp));
    check("frame_done", 32'(bus_if.frame_done), 32'(g.done));
    check("busy",       32'(bus_if.busy),       32'(g.busy));
    obs_tick = bus_if.bit_tick;
    obs_done = bus_if.frame_done;
  endtask

  task automatic run_until(input int b, input int e);
    int n = 0;
    while (!(m_run == 1 && m_bit == b && m_edge == e) && n < 400) begin
      step();
      n++;
    end
    check("reach_position", 32'(n < 400), 32'd1);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_edge"}, 32'(bus_if.edge_cnt),   32'd0);
    check({tag, "_bit"},  32'(bus_if.bit_cnt),    32'd0);
    check({tag, "_tick"}, 32'(bus_if.bit_tick),   32'd0);
    check({tag, "_samp"}, 32'(bus_if.sample_en),  32'd0);
    check({tag, "_done"}, 32'(bus_if.frame_done), 32'd0);
    check({tag, "_busy"}, 32'(bus_if.busy),       32'd0);
  endtask

  initial begin
    int last_tick;
    int last_done;
    int done_cyc;
    int ndone;
    bit found;

    RST = 1'b0;
    bus_if.enable     = 1'b1;
    bus_if.prescale   = 6'd8;
    bus_if.frame_bits = 4'd10;
    set_rs(1'b0);
    model_reset();

    // Reset holds everything at zero even with enable high
    repeat (2) @(posedge CLK);
    #1;
    check_idle_zero("reset");
    RST = 1'b1;
    step();
    check("first_run_edge", 32'(bus_if.edge_cnt), 32'd0);
    check("first_run_busy", 32'(bus_if.busy), 32'd1);

    // Nominal 8x10 frames
    last_tick = -1;
    ndone = 0;
    for (int i = 0; i < 160; i++) begin
      step();
      if (obs_tick) begin
        if (last_tick >= 0) check("tick_period_8", 32'(cyc - last_tick), 32'd8);
        last_tick = cyc;
      end
      if (obs_done) begin
        ndone++;
        check("done_at_bit9",  32'(bus_if.bit_cnt),  32'd9);
        check("done_at_edge7", 32'(bus_if.edge_cnt), 32'd7);
      end
    end
    check("done_count_160", 32'(ndone), 32'd2);

    // Mid-frame prescale change takes effect only at the next frame
    run_until(4, 0);
    bus_if.prescale = 6'd16;
    last_tick = -1;
    done_cyc = -1;
    for (int i = 0; i < 200 && done_cyc < 0; i++) begin
      step();
      if (obs_tick) begin
        if (last_tick >= 0) check("old_frame_period", 32'(cyc - last_tick), 32'd8);
        last_tick = cyc;
      end
      if (obs_done) done_cyc = cyc;
    end
    check("reconf_done_seen", 32'(done_cyc >= 0), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (obs_tick) begin
        found = 1'b1;
        check("new_frame_period", 32'(cyc - done_cyc), 32'd16);
      end
    end
    check("new_tick_seen", 32'(found), 32'd1);

    // Clamping: prescale 2 -> 4, frame_bits 1 -> 2
    bus_if.enable = 1'b0;
    step();
    bus_if.prescale   = 6'd2;
    bus_if.frame_bits = 4'd1;
    bus_if.enable     = 1'b1;
    step();
    last_done = -1;
    ndone = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (obs_done) begin
        if (last_done >= 0) check("clamp_done_period", 32'(cyc - last_done), 32'd8);
        last_done = cyc;
        ndone++;
      end
    end
    check("clamp_done_count", 32'(ndone), 32'd3);

    // Abort mid-frame
    bus_if.enable = 1'b0;
    step();
    bus_if.prescale   = 6'd8;
    bus_if.frame_bits = 4'd10;
    bus_if.enable     = 1'b1;
    step();
    run_until(5, 3);
    bus_if.enable = 1'b0;
    step();
    check_idle_zero("abort");

    // Enable dropped on the frame_done cycle
    bus_if.enable = 1'b1;
    step();
    run_until(9, 7);
    check("pre_drop_done", 32'(bus_if.frame_done), 32'd1);
    bus_if.enable = 1'b0;
    step();
    check_idle_zero("drop_on_done");

    // Largest frame length
    bus_if.prescale   = 6'd4;
    bus_if.frame_bits = 4'd15;
    bus_if.enable     = 1'b1;
    step();
    ndone = 0;
    for (int i = 0; i < 130; i++) begin
      step();
      if (obs_done) begin
        ndone++;
        check("max_done_bit", 32'(bus_if.bit_cnt), 32'd14);
      end
    end
    check("max_done_count", 32'(ndone), 32'd2);

`ifdef FRAME_BIT_TIMER_RESYNC_EN
    // Phase realignment mid-bit and on the last edge
    bus_if.enable = 1'b0;
    step();
    bus_if.prescale   = 6'd8;
    bus_if.frame_bits = 4'd10;
    bus_if.enable     = 1'b1;
    step();
    run_until(2, 5);
    set_rs(1'b1);
    step();
    set_rs(1'b0);
    check("resync_mid_edge", 32'(bus_if.edge_cnt), 32'd0);
    check("resync_mid_bit",  32'(bus_if.bit_cnt),  32'd2);
    run_until(2, 7);
    set_rs(1'b1);
    step();
    set_rs(1'b0);
    check("resync_last_edge", 32'(bus_if.edge_cnt), 32'd0);
    check("resync_last_bit",  32'(bus_if.bit_cnt),  32'd3);
`endif

    // Asynchronous reset in the middle of a frame
    bus_if.prescale   = 6'd8;
    bus_if.frame_bits = 4'd10;
    bus_if.enable     = 1'b1;
    repeat (13) step();
    #3;
    RST = 1'b0;
    #1;
    check_idle_zero("async_rst");
    model_reset();
    @(posedge CLK);
    #1;
    check_idle_zero("rst_held");
    RST = 1'b1;
    step();
    check("post_rst_busy", 32'(bus_if.busy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
